csr_trap_unit: RTL
==================

Name: csr_trap_unit

Overview:
- Machine-mode CSR file and trap sequencer for the single-issue RV32 core.
- Consumes the decoder's trap code, CSR read/write address, write enable and write-source select.
- Holds mstatus, mtvec, mepc and mcause, and supplies CSR read data for the register write-back mux.
- Runs a small FSM that stalls the core, saves state on ecall or illegal instruction, and redirects the PC on trap entry and on mret.

Parameters:
- XLEN, 32, data/address width.
- MTVEC_RESET, 32'h0000_0000, mtvec value after reset.
- MSTATUS_RESET, 32'h0000_1800, mstatus value after reset (MPP=11, MIE=0, MPIE=0).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- trap  in  2  00 none, 01 ecall, 10 illegal/unimplemented, 11 mret.
- inst_pc  in  XLEN  PC of the instruction currently in decode/execute.
- csr_read_addr  in  12  CSR to read.
- csr_write_addr  in  12  CSR to write.
- csr_write  in  1  CSR write enable.
- csr_write_src  in  1  0: wdata = rs1_data; 1: wdata = alu_result.
- rs1_data  in  XLEN  register source operand.
- alu_result  in  XLEN  ALU output (set/clear forms).
- csr_read_data  out  XLEN  combinational read of csr_read_addr.
- stall  out  1  freeze PC and pipeline registers.
- redirect_valid  out  1  one-cycle pulse; PC must load redirect_pc.
- redirect_pc  out  XLEN  trap vector or mepc.

Behaviour:
- Reset values:
  - mstatus=MSTATUS_RESET, mtvec=MTVEC_RESET, mepc=0, mcause=0.
  - FSM=IDLE, redirect_valid=0, redirect_pc=0.
  - stall follows the combinational rule below.
- CSR map: 0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause. Unmapped addresses read 0; writes to them are dropped.
- mstatus field rules:
  - Only MIE[3] and MPIE[7] are writable.
  - MPP[12:11] always reads 11.
  - All other bits read 0.
- mtvec write: bits[1:0] forced to 00 (direct mode only).
- mepc write: bits[1:0] forced to 00.
- CSR reads are combinational. Read-during-write to the same CSR returns the old value; the new value is visible the next cycle.
- CSR writes commit only when FSM=IDLE, trap=00 and csr_write=1. If trap!=00 in the same cycle, the trap wins and the write is dropped.
- FSM states: IDLE, SAVE, RESTORE, REDIRECT.
- IDLE:
  - trap=01 or 10: latch inst_pc and cause (ecall → 11, illegal → 2) → SAVE.
  - trap=11: → RESTORE.
  - trap=00: remain in IDLE.
- SAVE (1 cycle):
  - mepc <= latched pc & ~3; mcause <= latched cause.
  - MPIE <= MIE; MIE <= 0.
  - redirect_pc <= mtvec. → REDIRECT.
- RESTORE (1 cycle):
  - MIE <= MPIE; MPIE <= 1.
  - redirect_pc <= mepc. → REDIRECT.
- REDIRECT (1 cycle): redirect_valid=1 → IDLE.
- stall:
  - Combinational 1 when FSM=IDLE and trap!=00, and throughout SAVE and RESTORE.
  - 0 in REDIRECT, so the PC loads redirect_pc on that edge.
- Latency: trap seen at cycle N → redirect_valid high in cycle N+2; stall high in cycles N and N+1.
- trap input is ignored outside IDLE, because the decoder output is frozen by stall.
- A trap arriving in the cycle after REDIRECT (FSM back in IDLE) is accepted normally.
- A reset asserted in any state returns the FSM to IDLE with redirect_valid=0 next cycle; a partially saved state is discarded and CSRs return to reset values.

Decomposition:
- Shared package/header (alongside the AluOp constants) holds:
  - CSR address constants.
  - Trap code constants (TRAP_NONE, TRAP_ECALL, TRAP_ILLEGAL, TRAP_MRET).
  - mcause values.
  - FSM state encoding.
- One natural sub-module: csr_regfile, holding storage, field masking and the combinational read. The FSM stays in csr_trap_unit.

Test Plan:
- Reset, then read 0x300/0x305/0x341/0x342 → 0x1800 / 0x0 / 0x0 / 0x0; stall=0, redirect_valid=0.
- csrw mtvec: addr 0x305, rs1_data=0x100, src=0; next cycle read 0x305 → 0x100. Write 0x103 → reads 0x100. Write to 0x7C0 → that CSR reads 0, no other CSR changes.
- ecall at inst_pc=0x40 with mtvec=0x100, MIE=1:
  - stall=1 in cycles N and N+1; redirect_valid=1 with redirect_pc=0x100 in cycle N+2.
  - Afterwards mepc=0x40, mcause=11, MIE=0, MPIE=1.
- mret after the previous test: redirect_pc=0x40 in cycle N+2; afterwards MIE=1, MPIE=1.
- Illegal trap (10) asserted together with csr_write=1 to mepc: mcause=2, mepc=inst_pc, and the CSR write is dropped.
- rst asserted while in SAVE: next cycle FSM=IDLE, redirect_valid=0, mepc=0. No redirect pulse ever appears.

Source files
------------

// File: rtl/csr_trap_unit_pkg.sv
// Shared constants for the machine-mode CSR file and trap sequencer.
package csr_trap_unit_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // Trap codes from the decoder
  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ECALL   = 2'b01;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b10;
  localparam logic [1:0] TRAP_MRET    = 2'b11;

  // mcause exception codes (interrupt bit is never set by this unit)
  localparam logic [3:0] MCAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] MCAUSE_ECALL_M = 4'd11;

  typedef enum logic [1:0] {
    StIdle,
    StSave,
    StRestore,
    StRedirect
  } trap_state_e;

  // mstatus as seen by software: MPP hardwired to M-mode, only MIE/MPIE live.
  function automatic logic [31:0] mstatus_pack(logic mpie, logic mie);
    logic [31:0] val;
    val       = 32'h0000_1800;
    val[7]    = mpie;
    val[3]    = mie;
    return val;
  endfunction

endpackage

// File: rtl/csr_trap_unit_csr_regfile.sv
// Storage for mstatus/mtvec/mepc/mcause with field masking and combinational read.
module csr_trap_unit_csr_regfile
  import csr_trap_unit_pkg::*;
#(
  parameter int unsigned     XLEN          = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET   = 32'h0000_0000,
  parameter logic [XLEN-1:0] MSTATUS_RESET = 32'h0000_1800
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            write_en_i,
  input  logic [11:0]     write_addr_i,
  input  logic [XLEN-1:0] write_data_i,
  input  logic [11:0]     read_addr_i,
  output logic [XLEN-1:0] read_data_o,
  input  logic            save_en_i,
  input  logic [XLEN-1:0] save_pc_i,
  input  logic [3:0]      save_cause_i,
  input  logic            restore_en_i,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o
);

  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;

  // Next-state: trap save/restore take priority over software writes.
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (save_en_i) begin
      mepc_d   = {save_pc_i[XLEN-1:2], 2'b00};
      mcause_d = {{(XLEN-4){1'b0}}, save_cause_i};
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (restore_en_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (write_en_i) begin
      case (write_addr_i)
        CSR_MSTATUS: begin
          mie_d  = write_data_i[3];
          mpie_d = write_data_i[7];
        end
        CSR_MTVEC:  mtvec_d  = {write_data_i[XLEN-1:2], 2'b00};
        CSR_MEPC:   mepc_d   = {write_data_i[XLEN-1:2], 2'b00};
        CSR_MCAUSE: mcause_d = write_data_i;
        default: ;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q    <= MSTATUS_RESET[3];
      mpie_q   <= MSTATUS_RESET[7];
      mtvec_q  <= MTVEC_RESET;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else begin
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

  // Combinational read of current (pre-write) values; unmapped reads 0.
  always_comb begin
    read_data_o = '0;
    case (read_addr_i)
      CSR_MSTATUS: read_data_o = XLEN'(mstatus_pack(mpie_q, mie_q));
      CSR_MTVEC:   read_data_o = mtvec_q;
      CSR_MEPC:    read_data_o = mepc_q;
      CSR_MCAUSE:  read_data_o = mcause_q;
      default:     read_data_o = '0;
    endcase
  end

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file plus trap entry / mret sequencer for the RV32 core.
module csr_trap_unit
  import csr_trap_unit_pkg::*;
#(
  parameter int unsigned     XLEN          = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET   = 32'h0000_0000,
  parameter logic [XLEN-1:0] MSTATUS_RESET = 32'h0000_1800
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      trap,
  input  logic [XLEN-1:0] inst_pc,
  input  logic [11:0]     csr_read_addr,
  input  logic [11:0]     csr_write_addr,
  input  logic            csr_write,
  input  logic            csr_write_src,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] csr_read_data,
  output logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  trap_state_e     state_q;
  logic [XLEN-1:0] pc_q;
  logic [3:0]      cause_q;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic            csr_we;
  logic [XLEN-1:0] csr_wdata;

  // A pending trap in the same cycle wins over a CSR write.
  assign csr_we    = (state_q == StIdle) && (trap == TRAP_NONE) && csr_write;
  assign csr_wdata = csr_write_src ? alu_result : rs1_data;

  // Stall drops in REDIRECT so the PC loads redirect_pc on that edge.
  assign stall = ((state_q == StIdle) && (trap != TRAP_NONE)) ||
                 (state_q == StSave) || (state_q == StRestore);

  csr_trap_unit_csr_regfile #(
    .XLEN          (XLEN),
    .MTVEC_RESET   (MTVEC_RESET),
    .MSTATUS_RESET (MSTATUS_RESET)
  ) u_regfile (
    .clk          (clk),
    .rst          (rst),
    .write_en_i   (csr_we),
    .write_addr_i (csr_write_addr),
    .write_data_i (csr_wdata),
    .read_addr_i  (csr_read_addr),
    .read_data_o  (csr_read_data),
    .save_en_i    (state_q == StSave),
    .save_pc_i    (pc_q),
    .save_cause_i (cause_q),
    .restore_en_i (state_q == StRestore),
    .mtvec_o      (mtvec),
    .mepc_o       (mepc)
  );

  // Trap sequencer FSM with registered redirect outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      pc_q           <= '0;
      cause_q        <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (trap == TRAP_ECALL || trap == TRAP_ILLEGAL) begin
            pc_q    <= inst_pc;
            cause_q <= (trap == TRAP_ECALL) ? MCAUSE_ECALL_M : MCAUSE_ILLEGAL;
            state_q <= StSave;
          end else if (trap == TRAP_MRET) begin
            state_q <= StRestore;
          end
        end
        StSave: begin
          redirect_pc    <= mtvec;
          redirect_valid <= 1'b1;
          state_q        <= StRedirect;
        end
        StRestore: begin
          redirect_pc    <= mepc;
          redirect_valid <= 1'b1;
          state_q        <= StRedirect;
        end
        StRedirect: state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

endmodule
